// File: rtl/mem_io_responder.sv
// mem_io_responder
// Memory-side responder for the CPU byte bus. Serves a 1-cycle-latency RAM
// and the I/O window at 0x30000 (UART TX/RX FIFOs, cycle counter snapshot,
// program-stop flag).
// Ports:
//   clk_in, rst_in (async active-low)   clock / reset
//   cpu_active                          bus transaction qualifier, counter enable
//   cpu_a, cpu_wr, cpu_wdata            CPU address / direction / write byte
//   cpu_rdata                           registered read byte (held between reads)
//   io_buffer_full                      TX FIFO at or above TX_DEPTH-2 entries
//   tx_data, tx_valid, tx_ready         UART transmit handshake (registered head)
//   rx_data, rx_valid                   UART receive push
//   program_stop                        sticky stop flag
module mem_io_responder #(
    parameter int ADDR_BITS = 17,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        cpu_active,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_stop
);
    localparam int TXW = $clog2(TX_DEPTH);
    localparam int RXW = $clog2(RX_DEPTH);
    localparam logic [TXW:0]   TX_FULL_C  = (TXW+1)'(TX_DEPTH);
    localparam logic [TXW:0]   TX_HIGH_C  = (TXW+1)'(TX_DEPTH - 2);
    localparam logic [TXW:0]   TX_CNT1_C  = (TXW+1)'(1);
    localparam logic [TXW:0]   TX_ZERO_C  = (TXW+1)'(0);
    localparam logic [TXW-1:0] TX_PTR1_C  = TXW'(1);
    localparam logic [RXW:0]   RX_FULL_C  = (RXW+1)'(RX_DEPTH);
    localparam logic [RXW:0]   RX_CNT1_C  = (RXW+1)'(1);
    localparam logic [RXW:0]   RX_ZERO_C  = (RXW+1)'(0);
    localparam logic [RXW-1:0] RX_PTR1_C  = RXW'(1);

    // Storage arrays (no reset: RAM contents survive rst_in)
    logic [7:0] ram_r    [0:(2**ADDR_BITS)-1];
    logic [7:0] tx_mem_r [0:TX_DEPTH-1];
    logic [7:0] rx_mem_r [0:RX_DEPTH-1];

    logic [TXW-1:0] tx_wr_ptr_r, tx_rd_ptr_r, tx_rd_next_s;
    logic [TXW:0]   tx_count_r, tx_count_next_s, tx_rem_s;
    logic [RXW-1:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic [RXW:0]   rx_count_r, rx_count_next_s;
    logic [31:0]    cnt_r, cnt_snap_r;
    logic [7:0]     cpu_rdata_r, tx_data_r, tx_data_next_s;
    logic           tx_valid_r, io_full_r, stop_r;

    logic                 io_sel_s;
    logic [ADDR_BITS-1:0] ram_idx_s;
    logic [2:0]           io_off_s;
    logic                 ram_we_s, rd_en_s, snap_s, stop_set_s, rx_pop_s;
    logic                 tx_push_req_s, tx_push_s, tx_pop_s, rx_push_s;
    logic [7:0]           rd_data_s, tx_push_data_s;
    logic                 unused_addr_s;

    assign io_sel_s      = (cpu_a[17:16] == 2'b11);
    assign ram_idx_s     = cpu_a[ADDR_BITS-1:0];
    assign io_off_s      = cpu_a[2:0];
    assign unused_addr_s = ^cpu_a[31:18];

    // A full TX FIFO still accepts a push when the UART pops in the same cycle;
    // likewise a full RX FIFO accepts a byte when the CPU pops in that cycle.
    assign tx_pop_s  = tx_valid_r & tx_ready;
    assign tx_push_s = tx_push_req_s & ((tx_count_r != TX_FULL_C) | tx_pop_s);
    assign rx_push_s = rx_valid & ((rx_count_r != RX_FULL_C) | rx_pop_s);

    // Bus decode: classify the current transaction and select the read byte
    always_comb begin
        ram_we_s       = 1'b0;
        rd_en_s        = 1'b0;
        rd_data_s      = 8'h00;
        snap_s         = 1'b0;
        stop_set_s     = 1'b0;
        rx_pop_s       = 1'b0;
        tx_push_req_s  = 1'b0;
        tx_push_data_s = 8'h00;
        if (cpu_active) begin
            if (cpu_wr) begin
                if (!io_sel_s) begin
                    ram_we_s = 1'b1;
                end else begin
                    case (io_off_s)
                        3'd0: begin
                            // NUL bytes are not forwarded to the UART
                            if (cpu_wdata != 8'h00) begin
                                tx_push_req_s  = 1'b1;
                                tx_push_data_s = cpu_wdata;
                            end else begin
                                tx_push_req_s  = 1'b0;
                            end
                        end
                        3'd4: begin
                            stop_set_s     = 1'b1;
                            tx_push_req_s  = 1'b1;
                            tx_push_data_s = 8'h00;
                        end
                        default: tx_push_req_s = 1'b0;
                    endcase
                end
            end else begin
                rd_en_s = 1'b1;
                if (!io_sel_s) begin
                    rd_data_s = ram_r[ram_idx_s];
                end else begin
                    case (io_off_s)
                        3'd0: begin
                            if (rx_count_r != RX_ZERO_C) begin
                                rx_pop_s  = 1'b1;
                                rd_data_s = rx_mem_r[rx_rd_ptr_r];
                            end else begin
                                rd_data_s = 8'h00;
                            end
                        end
                        // Byte 0 comes straight from the live counter; the
                        // upper bytes come from the snapshot taken with it.
                        3'd4: begin
                            snap_s    = 1'b1;
                            rd_data_s = cnt_r[7:0];
                        end
                        3'd5: rd_data_s = cnt_snap_r[15:8];
                        3'd6: rd_data_s = cnt_snap_r[23:16];
                        3'd7: rd_data_s = cnt_snap_r[31:24];
                        default: rd_data_s = 8'h00;
                    endcase
                end
            end
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // FIFO next-state: counts, TX read pointer and the next registered TX head
    always_comb begin
        tx_count_next_s = tx_count_r;
        tx_rem_s        = tx_count_r;
        tx_rd_next_s    = tx_rd_ptr_r;
        tx_data_next_s  = 8'h00;
        rx_count_next_s = rx_count_r;
        case ({tx_push_s, tx_pop_s})
            2'b10:   tx_count_next_s = tx_count_r + TX_CNT1_C;
            2'b01:   tx_count_next_s = tx_count_r - TX_CNT1_C;
            default: tx_count_next_s = tx_count_r;
        endcase
        if (tx_pop_s) begin
            tx_rem_s     = tx_count_r - TX_CNT1_C;
            tx_rd_next_s = tx_rd_ptr_r + TX_PTR1_C;
        end else begin
            tx_rem_s     = tx_count_r;
            tx_rd_next_s = tx_rd_ptr_r;
        end
        // If nothing older survives this edge, the new head is the byte being pushed
        if (tx_count_next_s == TX_ZERO_C) begin
            tx_data_next_s = 8'h00;
        end else if (tx_rem_s == TX_ZERO_C) begin
            tx_data_next_s = tx_push_data_s;
        end else begin
            tx_data_next_s = tx_mem_r[tx_rd_next_s];
        end
        case ({rx_push_s, rx_pop_s})
            2'b10:   rx_count_next_s = rx_count_r + RX_CNT1_C;
            2'b01:   rx_count_next_s = rx_count_r - RX_CNT1_C;
            default: rx_count_next_s = rx_count_r;
        endcase
    end

    // Storage writes: RAM, TX and RX FIFO entries
    always_ff @(posedge clk_in) begin
        if (ram_we_s)  ram_r[ram_idx_s]       <= cpu_wdata;
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r] <= tx_push_data_s;
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r] <= rx_data;
    end

    // Control state: pointers, counters, snapshot and registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wr_ptr_r <= {TXW{1'b0}};
            tx_rd_ptr_r <= {TXW{1'b0}};
            tx_count_r  <= TX_ZERO_C;
            rx_wr_ptr_r <= {RXW{1'b0}};
            rx_rd_ptr_r <= {RXW{1'b0}};
            rx_count_r  <= RX_ZERO_C;
            cnt_r       <= 32'h0000_0000;
            cnt_snap_r  <= 32'h0000_0000;
            cpu_rdata_r <= 8'h00;
            tx_data_r   <= 8'h00;
            tx_valid_r  <= 1'b0;
            io_full_r   <= 1'b0;
            stop_r      <= 1'b0;
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + TX_PTR1_C;
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + RX_PTR1_C;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + RX_PTR1_C;
            tx_rd_ptr_r <= tx_rd_next_s;
            tx_count_r  <= tx_count_next_s;
            rx_count_r  <= rx_count_next_s;
            tx_data_r   <= tx_data_next_s;
            tx_valid_r  <= (tx_count_next_s != TX_ZERO_C);
            io_full_r   <= (tx_count_next_s >= TX_HIGH_C);
            if (cpu_active) cnt_r <= cnt_r + 32'd1;
            if (snap_s)     cnt_snap_r <= cnt_r;
            if (rd_en_s)    cpu_rdata_r <= rd_data_s;
            if (stop_set_s) stop_r <= 1'b1;
        end
    end

    assign cpu_rdata      = cpu_rdata_r;
    assign io_buffer_full = io_full_r;
    assign tx_data        = tx_data_r;
    assign tx_valid       = tx_valid_r;
    assign program_stop   = stop_r;
endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: a table of single-cycle vectors for RAM, RX,
// TX and stop behaviour, followed by hand-written multi-cycle sequences for
// async reset, RAM preservation, TX fill/drain and the cycle counter snapshot.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        cpu_active = 1'b0;
    logic [31:0] cpu_a = 32'h0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        program_stop;

    int checks = 0;
    int failures = 0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_active(cpu_active),
        .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .program_stop(program_stop)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        act;
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic [7:0]  e_rdata;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic        e_full;
        logic        e_stop;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic act, input logic wr, input logic [31:0] addr, input logic [7:0] wd);
        cpu_active = act;
        cpu_wr     = wr;
        cpu_a      = addr;
        cpu_wdata  = wd;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rst_in   = 1'b0;
        step();
        step();
        rst_in   = 1'b1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] rd, input logic txv,
                           input logic [7:0] txd, input logic full, input logic stop);
        chk({tag, "_rdata"}, {24'h0, cpu_rdata}, {24'h0, rd});
        chk({tag, "_txv"},   {31'h0, tx_valid}, {31'h0, txv});
        chk({tag, "_txd"},   {24'h0, tx_data},  {24'h0, txd});
        chk({tag, "_full"},  {31'h0, io_buffer_full}, {31'h0, full});
        chk({tag, "_stop"},  {31'h0, program_stop}, {31'h0, stop});
    endtask

    // Watchdog: the run uses fixed cycle counts, this only guards against a stuck simulator
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        //          act  wr   addr          wd    txr  rxv  rxd    rdata txv  txd   full stop
        vecs[0]  = '{1'b1,1'b1,32'h0000_0010,8'h5A,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,32'h0000_0010,8'h00,1'b0,1'b0,8'h00, 8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b1,32'h0000_0020,8'hC3,1'b0,1'b0,8'h00, 8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[3]  = '{1'b1,1'b0,32'h0000_0020,8'h00,1'b0,1'b0,8'h00, 8'hC3,1'b0,8'h00,1'b0,1'b0};
        vecs[4]  = '{1'b1,1'b0,32'h0000_0010,8'h00,1'b0,1'b0,8'h00, 8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,32'h0000_0010,8'hFF,1'b0,1'b0,8'h00, 8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[6]  = '{1'b1,1'b0,32'h0000_0020,8'h00,1'b0,1'b0,8'h00, 8'hC3,1'b0,8'h00,1'b0,1'b0};
        vecs[7]  = '{1'b1,1'b0,32'h0000_0010,8'h00,1'b0,1'b0,8'h00, 8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[8]  = '{1'b0,1'b0,32'h0000_0000,8'h00,1'b0,1'b1,8'h31, 8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,32'h0000_0000,8'h00,1'b0,1'b1,8'h32, 8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h31,1'b0,8'h00,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h32,1'b0,8'h00,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,32'h0003_0000,8'h00,1'b0,1'b1,8'h77, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h77,1'b0,8'h00,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,32'h0003_0001,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b1,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b1,32'h0003_0000,8'h41,1'b0,1'b0,8'h00, 8'h00,1'b1,8'h41,1'b0,1'b0};
        vecs[18] = '{1'b0,1'b0,32'h0000_0000,8'h00,1'b1,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[19] = '{1'b0,1'b0,32'h0000_0000,8'h00,1'b0,1'b1,8'h55, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[20] = '{1'b0,1'b0,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[21] = '{1'b1,1'b0,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h55,1'b0,8'h00,1'b0,1'b0};
        vecs[22] = '{1'b1,1'b0,32'h0003_0000,8'h00,1'b0,1'b0,8'h00, 8'h00,1'b0,8'h00,1'b0,1'b0};
        vecs[23] = '{1'b1,1'b1,32'h0003_0004,8'h99,1'b0,1'b0,8'h00, 8'h00,1'b1,8'h00,1'b0,1'b1};
        vecs[24] = '{1'b1,1'b0,32'h0000_0010,8'h00,1'b1,1'b0,8'h00, 8'h5A,1'b0,8'h00,1'b0,1'b1};

        // Reset state
        do_reset();
        chk_all("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Table-driven single-cycle vectors
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].act, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            tx_ready = vecs[i].txr;
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_rdata, vecs[i].e_txv,
                    vecs[i].e_txd, vecs[i].e_full, vecs[i].e_stop);
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;

        // Async reset mid-stream: outputs clear immediately, pending read discarded
        drive(1'b1, 1'b1, 32'h0003_0004, 8'h12);
        step();
        chk("stop_again_txv", {31'h0, tx_valid}, 32'h1);
        drive(1'b1, 1'b0, 32'h0000_0010, 8'h00);
        step();
        chk("pre_rst_rdata", {24'h0, cpu_rdata}, 32'h5A);
        drive(1'b1, 1'b0, 32'h0000_0020, 8'h00);
        #2;
        rst_in = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        rst_in = 1'b1;
        step();
        chk_all("post_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Top RAM address, and RAM preserved across reset
        drive(1'b1, 1'b1, 32'h0001_FFFF, 8'hA7);
        step();
        do_reset();
        drive(1'b1, 1'b0, 32'h0001_FFFF, 8'h00);
        step();
        chk("ram_top_after_rst", {24'h0, cpu_rdata}, 32'hA7);
        drive(1'b1, 1'b0, 32'h0000_0010, 8'h00);
        step();
        chk("ram_low_after_rst", {24'h0, cpu_rdata}, 32'h5A);

        // TX fill with tx_ready low: full at 14, NUL skipped, overflow dropped
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, 1'b1, 32'h0003_0000, 8'h41 + 8'(i));
            step();
            chk($sformatf("tx_fill_full%0d", i + 1), {31'h0, io_buffer_full},
                (i + 1 >= 14) ? 32'h1 : 32'h0);
            chk($sformatf("tx_fill_head%0d", i + 1), {24'h0, tx_data}, 32'h41);
            if (i == 4) begin
                drive(1'b1, 1'b1, 32'h0003_0000, 8'h00);
                step();
                chk("tx_nul_full", {31'h0, io_buffer_full}, 32'h0);
            end
        end
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h4F); step();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h50); step();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h51); step();
        drive(1'b1, 1'b1, 32'h0003_0000, 8'h52); step();
        chk("tx_overflow_full", {31'h0, io_buffer_full}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        tx_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("tx_drain_valid%0d", j), {31'h0, tx_valid}, 32'h1);
            chk($sformatf("tx_drain_data%0d", j), {24'h0, tx_data}, 32'h41 + 32'(j));
            step();
            chk($sformatf("tx_drain_full%0d", j), {31'h0, io_buffer_full},
                (15 - j >= 14) ? 32'h1 : 32'h0);
        end
        chk("tx_drained_valid", {31'h0, tx_valid}, 32'h0);
        chk("tx_drained_data", {24'h0, tx_data}, 32'h0);
        tx_ready = 1'b0;

        // Cycle counter: 300 active cycles, then a consistent 4-byte snapshot
        do_reset();
        drive(1'b1, 1'b0, 32'h0000_0010, 8'h00);
        repeat (300) step();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00); step();
        chk("cnt300_b0", {24'h0, cpu_rdata}, 32'h2C);
        drive(1'b1, 1'b0, 32'h0003_0005, 8'h00); step();
        chk("cnt300_b1", {24'h0, cpu_rdata}, 32'h01);
        drive(1'b1, 1'b0, 32'h0003_0006, 8'h00); step();
        chk("cnt300_b2", {24'h0, cpu_rdata}, 32'h00);
        drive(1'b1, 1'b0, 32'h0003_0007, 8'h00); step();
        chk("cnt300_b3", {24'h0, cpu_rdata}, 32'h00);
        // Paused cycles must not advance the counter (304 expected)
        drive(1'b0, 1'b0, 32'h0003_0004, 8'h00);
        repeat (10) step();
        chk("pause_rdata_hold", {24'h0, cpu_rdata}, 32'h00);
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00); step();
        chk("cnt304_b0", {24'h0, cpu_rdata}, 32'h30);
        drive(1'b1, 1'b0, 32'h0003_0005, 8'h00); step();
        chk("cnt304_b1", {24'h0, cpu_rdata}, 32'h01);
        // Snapshot at 0x1FF: live counter has carried to 0x200 by the byte-1 read
        drive(1'b1, 1'b0, 32'h0000_0010, 8'h00);
        repeat (205) step();
        drive(1'b1, 1'b0, 32'h0003_0004, 8'h00); step();
        chk("cnt511_b0", {24'h0, cpu_rdata}, 32'hFF);
        drive(1'b1, 1'b0, 32'h0003_0005, 8'h00); step();
        chk("cnt511_b1", {24'h0, cpu_rdata}, 32'h01);
        drive(1'b1, 1'b0, 32'h0003_0003, 8'h00); step();
        chk("io_off3_zero", {24'h0, cpu_rdata}, 32'h00);
        drive(1'b1, 1'b0, 32'h0003_0005, 8'h00); step();
        chk("cnt511_b1_again", {24'h0, cpu_rdata}, 32'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
